arm_dp_ctrl: RTL and testbench
==============================

# arm_dp_ctrl

Multi-cycle control state machine for the ARM data-processing path: it sequences instruction fetch, operand decode and latch, shift/ALU execute and register/flag writeback. It samples the instruction register and the NZCV flags, checks the condition field and classifies the instruction into the three legal data-processing forms. It then drives the latch enables, write strobes and decoded select fields consumed by the register file, shifter, ALU and PC/IR registers. Illegal encodings park the machine in a sticky error state.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- run  input  1  level; 1 = keep executing, 0 = stop at next instruction boundary
- inst  input  32  current IR contents
- NZCV  input  4  current CPSR flags {N,Z,C,V}
- Write_PC  output  1  PC <= PC+4 strobe
- Write_IR  output  1  IR <= memory data strobe
- LA / LB / LC  output  1 each  latch enables for operand registers A (Rn), B (Rm), C (Rs)
- LF  output  1  latch enable for ALU result F and result flags
- Write_Reg  output  1  register-file write strobe, W_Addr = inst[15:12]
- Write_CPSR  output  1  flag update strobe
- ALU_op  output  4  registered inst[24:21]
- Shift_op  output  3  registered shift select
- rm_imm_s  output  1  0 = shifter data from Rm, 1 = 8-bit immediate
- rs_imm_s  output  2  00 = imm5 amount, 01 = Rs[7:0], 10 = rotate imm4*2
- S  output  1  registered inst[20]
- Error  output  1  sticky illegal-instruction flag
- state  output  3  current state code for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, ERR=5. All strobes are Moore outputs decoded from the registered state. Decoded fields are registered.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: Write_IR=1, Write_PC=1. Go to DECODE.
- DECODE: LA=LB=LC=1. Evaluate condition and class from inst. Register ALU_op, S, Shift_op, rm_imm_s and rs_imm_s.
  - Condition false: go to FETCH if run=1, else IDLE. Nothing is written.
  - Illegal: go to ERR.
  - Otherwise: go to EXEC.
- Legal classes, all requiring inst[15:12]!=1111:
  - inst[27:25]=000, inst[4]=0: Shift_op={inst[6:5],0}, rm_imm_s=0, rs_imm_s=00.
  - inst[27:25]=000, inst[4]=1, inst[7]=0: Shift_op={inst[6:5],1}, rm_imm_s=0, rs_imm_s=01.
  - inst[27:25]=001: Shift_op=111, rm_imm_s=1, rs_imm_s=10.
  - Any other encoding, including Rd=15, is illegal.
- Conditions:
  - EQ: Z; NE: !Z
  - CS: C; CC: !C
  - MI: N; PL: !N
  - VS: V; VC: !V
  - HI: C&!Z; LS: !C|Z
  - GE: N==V; LT: N!=V
  - GT: !Z&(N==V); LE: Z|(N!=V)
  - AL: 1
  - cond=1111 is illegal.
- EXEC: LF=1. Go to WB.
- WB:
  - Write_Reg=1 unless ALU_op[3:2]=10 (TST/TEQ/CMP/CMN).
  - Write_CPSR=S.
  - Go to FETCH if run=1, else IDLE.
- ERR: Error=1, all strobes 0. Held until rst.
- run is sampled only in IDLE, DECODE (condition-false path) and WB. Deasserting run mid-instruction completes the current instruction.

## Timing
- Reset: state=IDLE. All outputs are 0: strobes, ALU_op, Shift_op, rm_imm_s, rs_imm_s, S, Error.
- Executed instruction: 4 cycles (FETCH, DECODE, EXEC, WB). Back-to-back with run=1: one FETCH every 4 cycles.
- Condition-failed instruction: 2 cycles (FETCH, DECODE).
- Decoded fields:
  - Valid from the cycle after DECODE through WB.
  - Stable until the next DECODE.
  - Unchanged on the illegal path.
- Asynchronous rst in any state, including mid-EXEC or WB: outputs return to reset values immediately. The next cycle after release is IDLE, and no further strobe fires for the aborted instruction.
- The NZCV update from WB is visible to the DECODE of the next instruction, which is 2 cycles later.

## Configuration
- ARM_DP_COND_EN defined: condition evaluation as above. Condition-false instructions are skipped, and cond=1111 goes to ERR.
- Not defined: the condition field is ignored and every legal-class instruction executes as AL, including cond=1111. NZCV is unused. The DECODE→FETCH skip path does not exist.

## Test plan
- Reset, then run=1, inst=E0811002 (ADD r1,r1,r2): required response, in order:
  - Write_IR, Write_PC
  - LA/LB/LC
  - LF
  - Write_Reg=1, Write_CPSR=0
  - Fields latched: ALU_op=0100, Shift_op=000, rs_imm_s=00.
  - The machine is back in FETCH at cycle 5.
- inst=E1510002 (CMP): in WB, Write_Reg=0 and Write_CPSR=1, with ALU_op=1010 and S=1.
- inst=E3A00005 (MOV imm):
  - rm_imm_s=1, rs_imm_s=10, Shift_op=111.
  - inst=E0811312 (reg shift): rs_imm_s=01, Shift_op=001.
- With ARM_DP_COND_EN defined, inst=00811002 (ADDEQ):
  - NZCV=0000: DECODE→FETCH, no LF or Write_Reg.
  - NZCV=0100: full 4-cycle execute.
- inst=E0010291 (MUL) or E081F002 (Rd=15): DECODE→ERR. Error=1 persists while inst changes and run toggles. It clears only on rst.
- Assert rst during EXEC of E0811002: all outputs 0 immediately. After release, state=IDLE and no Write_Reg pulse ever appears for that instruction.

Source files
------------

// File: rtl/arm_dp_ctrl_if.sv
// Handshake/control bundle between the ARM data-path controller and its sequencer/data path.
// master drives run/inst/NZCV; slave (the controller) drives strobes, decoded fields and status.
interface arm_dp_ctrl_if;
  logic        run;
  logic [31:0] inst;
  logic [3:0]  NZCV;

  logic        Write_PC;
  logic        Write_IR;
  logic        LA;
  logic        LB;
  logic        LC;
  logic        LF;
  logic        Write_Reg;
  logic        Write_CPSR;
  logic [3:0]  ALU_op;
  logic [2:0]  Shift_op;
  logic        rm_imm_s;
  logic [1:0]  rs_imm_s;
  logic        S;
  logic        Error;
  logic [2:0]  state;

  modport master (
    output run, inst, NZCV,
    input  Write_PC, Write_IR, LA, LB, LC, LF, Write_Reg, Write_CPSR,
    input  ALU_op, Shift_op, rm_imm_s, rs_imm_s, S, Error, state
  );

  modport slave (
    input  run, inst, NZCV,
    output Write_PC, Write_IR, LA, LB, LC, LF, Write_Reg, Write_CPSR,
    output ALU_op, Shift_op, rm_imm_s, rs_imm_s, S, Error, state
  );
endinterface

// File: rtl/arm_dp_ctrl.sv
// ARM data-processing control FSM: FETCH/DECODE/EXEC/WB, 4 cycles per executed instruction, 2 when skipped.
// Condition-code evaluation is present only when ARM_DP_COND_EN is defined; illegal encodings park in sticky ERR.
module arm_dp_ctrl (
  input  logic          clk,
  input  logic          rst,
  arm_dp_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        s_q, s_d;
  logic [2:0]  shift_op_q, shift_op_d;
  logic        rm_imm_s_q, rm_imm_s_d;
  logic [1:0]  rs_imm_s_q, rs_imm_s_d;

  logic        cls_legal;
  logic [2:0]  dec_shift_op;
  logic        dec_rm_imm_s;
  logic [1:0]  dec_rs_imm_s;
  logic        cond_ok;
  logic        cond_illegal;
  logic        inst_illegal;

  // Instruction class: register/imm5 shift, register/Rs shift, or rotated 8-bit immediate.
  always_comb begin
    cls_legal    = 1'b0;
    dec_shift_op = 3'b000;
    dec_rm_imm_s = 1'b0;
    dec_rs_imm_s = 2'b00;
    if (bus.inst[27:25] == 3'b000 && !bus.inst[4]) begin
      cls_legal    = 1'b1;
      dec_shift_op = {bus.inst[6:5], 1'b0};
      dec_rm_imm_s = 1'b0;
      dec_rs_imm_s = 2'b00;
    end else if (bus.inst[27:25] == 3'b000 && bus.inst[4] && !bus.inst[7]) begin
      cls_legal    = 1'b1;
      dec_shift_op = {bus.inst[6:5], 1'b1};
      dec_rm_imm_s = 1'b0;
      dec_rs_imm_s = 2'b01;
    end else if (bus.inst[27:25] == 3'b001) begin
      cls_legal    = 1'b1;
      dec_shift_op = 3'b111;
      dec_rm_imm_s = 1'b1;
      dec_rs_imm_s = 2'b10;
    end
  end

`ifdef ARM_DP_COND_EN
  logic flag_n, flag_z, flag_c, flag_v;
  logic unused_inst;

  assign {flag_n, flag_z, flag_c, flag_v} = bus.NZCV;
  assign unused_inst = ^{bus.inst[19:16], bus.inst[11:8], bus.inst[3:0]};

  always_comb begin
    cond_ok      = 1'b0;
    cond_illegal = 1'b0;
    case (bus.inst[31:28])
      4'h0:    cond_ok = flag_z;
      4'h1:    cond_ok = !flag_z;
      4'h2:    cond_ok = flag_c;
      4'h3:    cond_ok = !flag_c;
      4'h4:    cond_ok = flag_n;
      4'h5:    cond_ok = !flag_n;
      4'h6:    cond_ok = flag_v;
      4'h7:    cond_ok = !flag_v;
      4'h8:    cond_ok = flag_c && !flag_z;
      4'h9:    cond_ok = !flag_c || flag_z;
      4'hA:    cond_ok = (flag_n == flag_v);
      4'hB:    cond_ok = (flag_n != flag_v);
      4'hC:    cond_ok = !flag_z && (flag_n == flag_v);
      4'hD:    cond_ok = flag_z || (flag_n != flag_v);
      4'hE:    cond_ok = 1'b1;
      default: cond_illegal = 1'b1;
    endcase
  end
`else
  // Without condition support every legal instruction runs as AL, so cond and flags are dead.
  logic unused_inst;

  assign unused_inst  = ^{bus.NZCV, bus.inst[31:28], bus.inst[19:16],
                          bus.inst[11:8], bus.inst[3:0]};
  assign cond_ok      = 1'b1;
  assign cond_illegal = 1'b0;
`endif

  // Rd = PC is rejected: the PC is sequenced only by Write_PC.
  assign inst_illegal = !cls_legal || (bus.inst[15:12] == 4'hF) || cond_illegal;

  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    s_d        = s_q;
    shift_op_d = shift_op_q;
    rm_imm_s_d = rm_imm_s_q;
    rs_imm_s_d = rs_imm_s_q;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (inst_illegal) begin
          state_d = S_ERR;
        end else begin
          alu_op_d   = bus.inst[24:21];
          s_d        = bus.inst[20];
          shift_op_d = dec_shift_op;
          rm_imm_s_d = dec_rm_imm_s;
          rs_imm_s_d = dec_rs_imm_s;
          if (cond_ok) state_d = S_EXEC;
          else         state_d = bus.run ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_op_q   <= 4'b0000;
      s_q        <= 1'b0;
      shift_op_q <= 3'b000;
      rm_imm_s_q <= 1'b0;
      rs_imm_s_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      s_q        <= s_d;
      shift_op_q <= shift_op_d;
      rm_imm_s_q <= rm_imm_s_d;
      rs_imm_s_q <= rs_imm_s_d;
    end
  end

  // Moore strobes: compare-class ops (TST/TEQ/CMP/CMN) only touch flags.
  always_comb begin
    bus.Write_PC   = 1'b0;
    bus.Write_IR   = 1'b0;
    bus.LA         = 1'b0;
    bus.LB         = 1'b0;
    bus.LC         = 1'b0;
    bus.LF         = 1'b0;
    bus.Write_Reg  = 1'b0;
    bus.Write_CPSR = 1'b0;
    bus.Error      = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.Write_PC = 1'b1;
        bus.Write_IR = 1'b1;
      end
      S_DECODE: begin
        bus.LA = 1'b1;
        bus.LB = 1'b1;
        bus.LC = 1'b1;
      end
      S_EXEC: begin
        bus.LF = 1'b1;
      end
      S_WB: begin
        bus.Write_Reg  = (alu_op_q[3:2] != 2'b10);
        bus.Write_CPSR = s_q;
      end
      S_ERR: begin
        bus.Error = 1'b1;
      end
      default: begin
        bus.Error = 1'b0;
      end
    endcase
  end

  assign bus.ALU_op   = alu_op_q;
  assign bus.S        = s_q;
  assign bus.Shift_op = shift_op_q;
  assign bus.rm_imm_s = rm_imm_s_q;
  assign bus.rs_imm_s = rs_imm_s_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_arm_dp_ctrl.sv
// Directed bench for arm_dp_ctrl: hand-computed strobe sequences, decoded fields, error and reset behaviour.
// Build with +define+ARM_DP_COND_EN to exercise the condition-code path.
module tb_arm_dp_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  arm_dp_ctrl_if bus ();

  arm_dp_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {Write_PC, Write_IR, LA, LB, LC, LF, Write_Reg, Write_CPSR}
  function automatic logic [7:0] strobes();
    return {bus.Write_PC, bus.Write_IR, bus.LA, bus.LB, bus.LC,
            bus.LF, bus.Write_Reg, bus.Write_CPSR};
  endfunction

  function automatic logic [22:0] all_outs();
    return {strobes(), bus.ALU_op, bus.Shift_op, bus.rm_imm_s,
            bus.rs_imm_s, bus.S, bus.Error, bus.state};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT sampled in FETCH; leaves one cycle after WB.
  task automatic exec_instr(input string tag, input logic [31:0] ins,
                            input logic [7:0] wb_exp, input logic [3:0] alu_exp,
                            input logic [2:0] sh_exp, input logic rm_exp,
                            input logic [1:0] rs_exp, input logic s_exp,
                            input logic [2:0] nxt_exp);
    bus.inst = ins;
    chk({tag, " fetch state"}, 32'(bus.state), 32'd1);
    chk({tag, " fetch strobes"}, 32'(strobes()), 32'h0C0);
    step();
    chk({tag, " decode state"}, 32'(bus.state), 32'd2);
    chk({tag, " decode strobes"}, 32'(strobes()), 32'h038);
    step();
    chk({tag, " exec state"}, 32'(bus.state), 32'd3);
    chk({tag, " exec strobes"}, 32'(strobes()), 32'h004);
    chk({tag, " fields"}, 32'({bus.ALU_op, bus.Shift_op, bus.rm_imm_s, bus.rs_imm_s, bus.S}),
        32'({alu_exp, sh_exp, rm_exp, rs_exp, s_exp}));
    step();
    chk({tag, " wb state"}, 32'(bus.state), 32'd4);
    chk({tag, " wb strobes"}, 32'(strobes()), 32'(wb_exp));
    step();
    chk({tag, " next state"}, 32'(bus.state), 32'(nxt_exp));
  endtask

  initial begin
    logic wr_seen;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    bus.run  = 1'b0;
    bus.inst = 32'h0;
    bus.NZCV = 4'b0000;

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'(all_outs()), 32'd0);

    rst     = 1'b0;
    bus.run = 1'b1;
    bus.inst = 32'hE0811002;
    chk("idle after release", 32'(bus.state), 32'd0);
    step();

    // ADD r1,r1,r2 ; CMP r1,r2 ; MOV r0,#5 ; ADD r1,r1,r2,LSL r3
    exec_instr("add", 32'hE0811002, 8'h02, 4'b0100, 3'b000, 1'b0, 2'b00, 1'b0, 3'd1);
    exec_instr("cmp", 32'hE1510002, 8'h01, 4'b1010, 3'b000, 1'b0, 2'b00, 1'b1, 3'd1);
    exec_instr("movi", 32'hE3A00005, 8'h02, 4'b1101, 3'b111, 1'b1, 2'b10, 1'b0, 3'd1);
    exec_instr("rsh", 32'hE0811312, 8'h02, 4'b0100, 3'b001, 1'b0, 2'b01, 1'b0, 3'd1);

`ifdef ARM_DP_COND_EN
    bus.NZCV = 4'b0000;
    bus.inst = 32'h00811002;
    step();
    chk("addeq z0 decode", 32'(bus.state), 32'd2);
    step();
    chk("addeq z0 skip state", 32'(bus.state), 32'd1);
    chk("addeq z0 skip strobes", 32'(strobes()), 32'h0C0);
    bus.NZCV = 4'b0100;
    exec_instr("addeq z1", 32'h00811002, 8'h02, 4'b0100, 3'b000, 1'b0, 2'b00, 1'b0, 3'd1);
`else
    bus.NZCV = 4'b0000;
    exec_instr("addeq nocond", 32'h00811002, 8'h02, 4'b0100, 3'b000, 1'b0, 2'b00, 1'b0, 3'd1);
    exec_instr("cond15 nocond", 32'hF0811002, 8'h02, 4'b0100, 3'b000, 1'b0, 2'b00, 1'b0, 3'd1);
`endif

    // run dropped mid-instruction: current one completes, then IDLE
    bus.run = 1'b0;
    exec_instr("stop", 32'hE0811002, 8'h02, 4'b0100, 3'b000, 1'b0, 2'b00, 1'b0, 3'd0);
    step();
    chk("idle hold", 32'(bus.state), 32'd0);
    chk("idle strobes", 32'(strobes()), 32'd0);
    bus.run = 1'b1;
    step();
    chk("restart fetch", 32'(bus.state), 32'd1);

    // MUL encoding -> ERR, fields keep the previous ADD values
    bus.inst = 32'hE0010291;
    step();
    step();
    chk("mul err state", 32'(bus.state), 32'd5);
    chk("mul err flag", 32'(bus.Error), 32'd1);
    chk("mul err strobes", 32'(strobes()), 32'd0);
    chk("mul fields held", 32'({bus.ALU_op, bus.Shift_op, bus.rm_imm_s, bus.rs_imm_s, bus.S}),
        32'({4'b0100, 3'b000, 1'b0, 2'b00, 1'b0}));
    for (int i = 0; i < 4; i++) begin
      bus.run  = i[0];
      bus.inst = (i[1]) ? 32'hE0811002 : 32'hE3A00005;
      step();
      chk("err sticky", 32'({bus.Error, bus.state}), 32'({1'b1, 3'd5}));
    end
    rst = 1'b1;
    #1;
    chk("err cleared by rst", 32'(all_outs()), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.run = 1'b1;
    step();
    chk("rd15 fetch", 32'(bus.state), 32'd1);
    bus.inst = 32'hE081F002;
    step();
    step();
    chk("rd15 err", 32'({bus.Error, bus.state}), 32'({1'b1, 3'd5}));

`ifdef ARM_DP_COND_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    bus.inst = 32'hF0811002;
    step();
    step();
    chk("cond15 err", 32'({bus.Error, bus.state}), 32'({1'b1, 3'd5}));
`endif

    // Async reset mid-EXEC aborts the instruction with no writeback
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    bus.inst = 32'hE0811002;
    step();
    step();
    chk("abort exec state", 32'(bus.state), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("abort async outputs", 32'(all_outs()), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.run = 1'b0;
    wr_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.Write_Reg || bus.state != 3'd0) wr_seen = 1'b1;
    end
    chk("abort no writeback", 32'(wr_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
